// File: rtl/sim_bus_arbiter.sv
// -----------------------------------------------------------------------------
// sim_bus_arbiter
//
// Round-robin arbiter that merges N_PORTS cbus-style masters onto a single
// downstream cbus slave (the shared simulation memory model). Once a master is
// granted it owns the slave port until the final response beat of its
// transaction (s_ready & s_last), so multi-beat bursts are never interleaved.
//
// Optional feature macro: SIM_BUS_WATCHDOG_EN
//   Defined   : a per-transaction cycle counter (wd_cnt) aborts a transaction
//               the slave never completes, sets the sticky err flag and hands
//               the owner one ready+last pulse with zero read data.
//   Undefined : err is tied to 0 and BUSY waits indefinitely.
//
// Parameters:
//   N_PORTS  number of masters (1..8)
//   ADDR_W   address width
//   DATA_W   data width (strobe width is DATA_W/8)
//   LEN_W    burst length field width (beats = len + 1)
//   TIMEOUT  watchdog limit in BUSY cycles (watchdog build only)
//
// Ports (per-master buses are flat, port i lives in slice i):
//   clk, reset                 clock, synchronous active-high reset
//   m_valid/m_is_write         per-master request valid / write flag
//   m_addr/m_size/m_len        per-master start address, log2 bytes, beats-1
//   m_strobe/m_data            per-master write byte enables / data (current beat)
//   m_ready/m_last             per-master beat handshake / final beat (owner only)
//   m_rdata                    read data broadcast to all masters
//   s_valid..s_data            owner's request fields towards the slave
//   s_ready/s_last/s_rdata     slave response
//   err                        sticky watchdog error
//
// Handshake semantics: a beat transfers in any cycle where the arbiter is BUSY
// and s_ready is high; that cycle is reflected to the owner as m_ready. The
// transaction ends on the beat where s_last is also high (m_last to the owner).
// The owner presents the next write beat's data/strobe in the cycle after each
// m_ready; the arbiter passes request fields straight through, unregistered.
// -----------------------------------------------------------------------------
module sim_bus_arbiter #(
    parameter int N_PORTS = 2,
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 64,
    parameter int LEN_W   = 4,
    parameter int TIMEOUT = 1024
) (
    input  logic                          clk,
    input  logic                          reset,

    input  logic [N_PORTS-1:0]            m_valid,
    input  logic [N_PORTS-1:0]            m_is_write,
    input  logic [N_PORTS*ADDR_W-1:0]     m_addr,
    input  logic [N_PORTS*3-1:0]          m_size,
    input  logic [N_PORTS*LEN_W-1:0]      m_len,
    input  logic [N_PORTS*DATA_W/8-1:0]   m_strobe,
    input  logic [N_PORTS*DATA_W-1:0]     m_data,
    output logic [N_PORTS-1:0]            m_ready,
    output logic [N_PORTS-1:0]            m_last,
    output logic [DATA_W-1:0]             m_rdata,

    output logic                          s_valid,
    output logic                          s_is_write,
    output logic [ADDR_W-1:0]             s_addr,
    output logic [2:0]                    s_size,
    output logic [LEN_W-1:0]              s_len,
    output logic [DATA_W/8-1:0]           s_strobe,
    output logic [DATA_W-1:0]             s_data,
    input  logic                          s_ready,
    input  logic                          s_last,
    input  logic [DATA_W-1:0]             s_rdata,

    output logic                          err
);

    localparam int STRB_W = DATA_W / 8;
    // Owner / pointer width; a single-port build still needs a 1-bit register.
    localparam int OW     = (N_PORTS > 1) ? $clog2(N_PORTS) : 1;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_BUSY = 1'b1;

    logic [0:0]    state;
    logic [OW-1:0] owner;
    logic [OW-1:0] rr_ptr;

    // Round-robin scan results (valid only while IDLE).
    logic          scan_found;
    logic [OW-1:0] scan_idx;
    logic [OW-1:0] scan_next;

    // Watchdog abort pulse; constant 0 when the watchdog is not built.
    logic          wd_fire;
    logic          busy;
    logic          done;

    assign busy = (state == ST_BUSY);
    // Transaction ends on the last response beat or on a watchdog abort.
    assign done = busy && ((s_ready && s_last) || wd_fire);

    // -------------------------------------------------------------------------
    // Round-robin scan: walk the request vector starting at rr_ptr, wrapping
    // modulo N_PORTS, and take the first set bit. The inner loop keeps every
    // bit select constant so the scan unrolls into a plain priority mux.
    // -------------------------------------------------------------------------
    always_comb begin
        scan_found = 1'b0;
        scan_idx   = '0;
        scan_next  = '0;
        for (int k = 0; k < N_PORTS; k++) begin
            for (int i = 0; i < N_PORTS; i++) begin
                if (!scan_found && m_valid[i] &&
                    (((int'(rr_ptr) + k) % N_PORTS) == i)) begin
                    scan_found = 1'b1;
                    scan_idx   = OW'(i);
                    scan_next  = OW'((i + 1) % N_PORTS);
                end
            end
        end
    end

    // -------------------------------------------------------------------------
    // Request mux towards the slave and response demux back to the owner.
    // Everything is zero while IDLE so slave responses are ignored then.
    // -------------------------------------------------------------------------
    always_comb begin
        s_valid    = 1'b0;
        s_is_write = 1'b0;
        s_addr     = '0;
        s_size     = '0;
        s_len      = '0;
        s_strobe   = '0;
        s_data     = '0;
        m_ready    = '0;
        m_last     = '0;
        if (busy) begin
            for (int i = 0; i < N_PORTS; i++) begin
                if (owner == OW'(i)) begin
                    // s_valid follows the owner even if it drops valid
                    // mid-transaction; the grant is held regardless.
                    s_valid    = m_valid[i];
                    s_is_write = m_is_write[i];
                    s_addr     = m_addr[i*ADDR_W +: ADDR_W];
                    s_size     = m_size[i*3 +: 3];
                    s_len      = m_len[i*LEN_W +: LEN_W];
                    s_strobe   = m_strobe[i*STRB_W +: STRB_W];
                    s_data     = m_data[i*DATA_W +: DATA_W];
                    m_ready[i] = s_ready || wd_fire;
                    m_last[i]  = (s_ready && s_last) || wd_fire;
                end
            end
        end
    end

    // A watchdog abort hands the owner zeroed read data rather than whatever
    // the stalled slave happens to drive.
    assign m_rdata = wd_fire ? '0 : s_rdata;

    // -------------------------------------------------------------------------
    // Grant FSM
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= ST_IDLE;
            owner  <= '0;
            rr_ptr <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (scan_found) begin
                        state  <= ST_BUSY;
                        owner  <= scan_idx;
                        // (i+1) mod N collapses to 0 for a single-port build.
                        rr_ptr <= scan_next;
                    end
                end
                ST_BUSY: begin
                    if (done) begin
                        state <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

`ifdef SIM_BUS_WATCHDOG_EN
    // -------------------------------------------------------------------------
    // Watchdog: wd_cnt is 0 in the first BUSY cycle and counts BUSY cycles,
    // so wd_cnt == TIMEOUT-1 marks the TIMEOUT-th BUSY cycle. That cycle is the
    // abort pulse; err is visible in the same cycle and then held sticky.
    // -------------------------------------------------------------------------
    localparam int WD_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

    logic [WD_W-1:0] wd_cnt;
    logic            err_q;

    assign wd_fire = busy && !(s_ready && s_last) &&
                     (wd_cnt == WD_W'(TIMEOUT - 1));
    assign err     = err_q || wd_fire;

    always_ff @(posedge clk) begin
        if (reset) begin
            wd_cnt <= '0;
            err_q  <= 1'b0;
        end else begin
            if (state == ST_IDLE) begin
                // Cleared here so it reads 0 on the first BUSY cycle.
                wd_cnt <= '0;
            end else if (!done) begin
                wd_cnt <= wd_cnt + WD_W'(1);
            end
            if (wd_fire) begin
                err_q <= 1'b1;
            end
        end
    end
`else
    // No watchdog: nothing can abort a transaction and err never sets.
    localparam int unused_timeout = TIMEOUT;

    assign wd_fire = 1'b0;
    assign err     = 1'b0;
`endif

endmodule

// File: tb/tb_sim_bus_arbiter.sv
// -----------------------------------------------------------------------------
// tb_sim_bus_arbiter
//
// Directed bench for sim_bus_arbiter. A 2-port instance covers single read,
// contention/alternation, write burst passthrough, mid-burst reset and the
// watchdog (or its absence); a 4-port instance covers rotation order.
// Inputs are driven 1 time unit after the rising edge, outputs are sampled
// 3 units after the edge (well before the next one).
// -----------------------------------------------------------------------------
module tb_sim_bus_arbiter;

  localparam int N2     = 2;
  localparam int N4     = 4;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 64;
  localparam int LEN_W  = 4;
  localparam int STRB_W = DATA_W / 8;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  // ---------------- 2-port DUT signals ----------------
  logic [N2-1:0]        m_valid = '0;
  logic [N2-1:0]        m_is_write = '0;
  logic [N2*ADDR_W-1:0] m_addr = '0;
  logic [N2*3-1:0]      m_size = '0;
  logic [N2*LEN_W-1:0]  m_len = '0;
  logic [N2*STRB_W-1:0] m_strobe = '0;
  logic [N2*DATA_W-1:0] m_data = '0;
  logic [N2-1:0]        m_ready;
  logic [N2-1:0]        m_last;
  logic [DATA_W-1:0]    m_rdata;
  logic                 s_valid;
  logic                 s_is_write;
  logic [ADDR_W-1:0]    s_addr;
  logic [2:0]           s_size;
  logic [LEN_W-1:0]     s_len;
  logic [STRB_W-1:0]    s_strobe;
  logic [DATA_W-1:0]    s_data;
  logic                 s_ready = 1'b0;
  logic                 s_last = 1'b0;
  logic [DATA_W-1:0]    s_rdata = '0;
  logic                 err;

  // ---------------- 4-port DUT signals ----------------
  logic [N4-1:0]        m4_valid = '0;
  logic [N4*ADDR_W-1:0] m4_addr = '0;
  logic [N4-1:0]        m4_ready;
  logic [N4-1:0]        m4_last;
  logic [DATA_W-1:0]    m4_rdata;
  logic                 s4_valid;
  logic                 s4_is_write;
  logic [ADDR_W-1:0]    s4_addr;
  logic [2:0]           s4_size;
  logic [LEN_W-1:0]     s4_len;
  logic [STRB_W-1:0]    s4_strobe;
  logic [DATA_W-1:0]    s4_data;
  logic                 s4_ready = 1'b0;
  logic                 s4_last = 1'b0;
  logic                 err4;

  sim_bus_arbiter #(
    .N_PORTS(N2), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .LEN_W(LEN_W), .TIMEOUT(16)
  ) u_dut (
    .clk(clk), .reset(reset),
    .m_valid(m_valid), .m_is_write(m_is_write), .m_addr(m_addr),
    .m_size(m_size), .m_len(m_len), .m_strobe(m_strobe), .m_data(m_data),
    .m_ready(m_ready), .m_last(m_last), .m_rdata(m_rdata),
    .s_valid(s_valid), .s_is_write(s_is_write), .s_addr(s_addr),
    .s_size(s_size), .s_len(s_len), .s_strobe(s_strobe), .s_data(s_data),
    .s_ready(s_ready), .s_last(s_last), .s_rdata(s_rdata),
    .err(err)
  );

  sim_bus_arbiter #(
    .N_PORTS(N4), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .LEN_W(LEN_W), .TIMEOUT(16)
  ) u_dut4 (
    .clk(clk), .reset(reset),
    .m_valid(m4_valid), .m_is_write({N4{1'b0}}), .m_addr(m4_addr),
    .m_size({N4*3{1'b0}}), .m_len({N4*LEN_W{1'b0}}),
    .m_strobe({N4*STRB_W{1'b0}}), .m_data({N4*DATA_W{1'b0}}),
    .m_ready(m4_ready), .m_last(m4_last), .m_rdata(m4_rdata),
    .s_valid(s4_valid), .s_is_write(s4_is_write), .s_addr(s4_addr),
    .s_size(s4_size), .s_len(s4_len), .s_strobe(s4_strobe), .s_data(s4_data),
    .s_ready(s4_ready), .s_last(s4_last), .s_rdata(64'h0),
    .err(err4)
  );

  // ---------------- scoreboard counters ----------------
  int tests = 0;
  int failed = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    tests++;
    assert (obs === expv) else begin
      failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Advance to just after the next rising edge; inputs are changed here.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Let combinational outputs settle before sampling.
  task automatic settle();
    #2;
  endtask

  // Two reset cycles with idle inputs; returns in cycle 0 after reset.
  task automatic do_reset();
    reset      = 1'b1;
    m_valid    = '0;
    m_is_write = '0;
    m_len      = '0;
    m4_valid   = '0;
    s_ready    = 1'b0;
    s_last     = 1'b0;
    s4_ready   = 1'b0;
    s4_last    = 1'b0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  int order[5] = '{0, 1, 2, 3, 0};

  initial begin
    m_addr[0 +: ADDR_W]      = 32'h0000_1000;
    m_addr[ADDR_W +: ADDR_W] = 32'h0000_2000;
    for (int i = 0; i < N4; i++) m4_addr[i*ADDR_W +: ADDR_W] = 32'h100 * i;

    // ---------- reset state + single read ----------
    do_reset();
    m_valid = 2'b01;
    settle();
    chk("rst_s_valid", s_valid, 0);
    chk("rst_m_ready", m_ready, 0);
    chk("rst_m_last",  m_last,  0);
    chk("rst_err",     err,     0);
    chk("rst_s_addr",  s_addr,  0);
    chk("rst4_s_valid", s4_valid, 0);
    tick(); settle();                             // cycle 1
    chk("rd_s_valid", s_valid, 1);
    chk("rd_s_addr",  s_addr,  32'h1000);
    chk("rd_s_is_write", s_is_write, 0);
    chk("rd_wait1_ready", m_ready, 0);
    tick(); settle();                             // cycle 2
    chk("rd_wait2_ready", m_ready, 0);
    tick();                                       // cycle 3
    s_ready = 1'b1; s_last = 1'b1; s_rdata = 64'hDEADBEEF_00000001;
    settle();
    chk("rd_m_ready", m_ready, 2'b01);
    chk("rd_m_last",  m_last,  2'b01);
    chk("rd_m_rdata", m_rdata, 64'hDEADBEEF_00000001);
    tick();                                       // cycle 4
    m_valid = '0; s_ready = 1'b0; s_last = 1'b0;
    settle();
    chk("rd_done_s_valid", s_valid, 0);
    chk("rd_done_m_ready", m_ready, 0);

    // ---------- contention / alternation ----------
    do_reset();
    m_valid = 2'b11;                              // cycle 0
    tick(); s_ready = 1'b1; s_last = 1'b1; settle();   // cycle 1
    chk("ct_g0_addr",  s_addr,  32'h1000);
    chk("ct_g0_ready", m_ready, 2'b01);
    tick(); settle();                             // cycle 2: bubble
    chk("ct_bubble_s_valid", s_valid, 0);
    chk("ct_bubble_ready",   m_ready, 0);
    tick(); settle();                             // cycle 3
    chk("ct_g1_addr",  s_addr,  32'h2000);
    chk("ct_g1_ready", m_ready, 2'b10);
    chk("ct_g1_last",  m_last,  2'b10);
    tick(); settle();                             // cycle 4: bubble
    chk("ct_bubble2_s_valid", s_valid, 0);
    tick(); settle();                             // cycle 5
    chk("ct_g2_addr",  s_addr,  32'h1000);
    chk("ct_g2_ready", m_ready, 2'b01);
    tick();
    m_valid = '0; s_ready = 1'b0; s_last = 1'b0;

    // ---------- write burst, port1, len=3 ----------
    m_valid = 2'b10;
    m_is_write = 2'b10;
    m_len[LEN_W +: LEN_W] = 4'd3;
    m_strobe[STRB_W +: STRB_W] = 8'hFF;
    m_size[3 +: 3] = 3'd3;
    m_data[DATA_W +: DATA_W] = 64'h11;
    for (int b = 0; b < 4; b++) begin
      tick();
      m_data[DATA_W +: DATA_W] = 64'h11 * (b + 1);
      s_ready = 1'b1;
      s_last  = (b == 3);
      settle();
      if (b == 0) begin
        chk("wb_s_is_write", s_is_write, 1);
        chk("wb_s_len",      s_len,      3);
        chk("wb_s_strobe",   s_strobe,   8'hFF);
        chk("wb_s_size",     s_size,     3);
      end
      chk($sformatf("wb_s_data_%0d", b), s_data, 64'h11 * (b + 1));
      chk($sformatf("wb_m_ready_%0d", b), m_ready, 2'b10);
      chk($sformatf("wb_m_last_%0d", b), m_last, (b == 3) ? 2'b10 : 2'b00);
    end
    tick();
    m_valid = '0; m_is_write = '0; s_ready = 1'b0; s_last = 1'b0;
    settle();
    chk("wb_done_s_valid", s_valid, 0);

    // ---------- reset during BUSY ----------
    m_valid = 2'b01;
    m_len[0 +: LEN_W] = 4'd3;
    tick(); s_ready = 1'b1; s_last = 1'b0; settle();   // beat 0
    chk("rb_owner0", m_ready, 2'b01);
    tick();                                       // beat 1
    tick(); reset = 1'b1;                         // beat 2, reset sampled here
    tick(); reset = 1'b0; m_valid = 2'b11; settle();
    chk("rb_idle_s_valid", s_valid, 0);
    chk("rb_idle_ready",   m_ready, 0);
    chk("rb_idle_last",    m_last,  0);
    tick(); s_last = 1'b1; settle();
    chk("rb_regrant_ready", m_ready, 2'b01);
    chk("rb_regrant_addr",  s_addr,  32'h1000);
    tick();
    m_valid = '0; s_ready = 1'b0; s_last = 1'b0;

    // ---------- N_PORTS=4 rotation ----------
    do_reset();
    m4_valid = 4'hF; s4_ready = 1'b1; s4_last = 1'b1;
    for (int g = 0; g < 5; g++) begin
      tick(); settle();
      chk($sformatf("rot_grant_%0d", g), m4_ready, 4'b0001 << order[g]);
      chk($sformatf("rot_addr_%0d", g), s4_addr, 32'h100 * order[g]);
      tick();
    end
    m4_valid = '0; s4_ready = 1'b0; s4_last = 1'b0;

`ifdef SIM_BUS_WATCHDOG_EN
    // ---------- watchdog, TIMEOUT=16 ----------
    do_reset();
    m_valid = 2'b01;
    s_rdata = 64'hCAFE_F00D;
    for (int k = 1; k <= 15; k++) begin
      tick(); settle();
      chk($sformatf("wd_pre_err_%0d", k), err, 0);
      chk($sformatf("wd_pre_ready_%0d", k), m_ready, 0);
    end
    tick(); settle();                             // BUSY cycle 16
    chk("wd_err",     err,     1);
    chk("wd_ready",   m_ready, 2'b01);
    chk("wd_last",    m_last,  2'b01);
    chk("wd_rdata",   m_rdata, 0);
    tick(); m_valid = '0; settle();
    chk("wd_idle_s_valid", s_valid, 0);
    chk("wd_sticky_0", err, 1);
    tick(); tick(); tick(); settle();
    chk("wd_sticky_1", err, 1);
    do_reset(); settle();
    chk("wd_err_cleared", err, 0);
`else
    // ---------- no watchdog: stall is held indefinitely ----------
    do_reset();
    m_valid = 2'b01;
    for (int k = 0; k < 40; k++) tick();
    settle();
    chk("nowd_err",     err,     0);
    chk("nowd_s_valid", s_valid, 1);
    chk("nowd_ready",   m_ready, 0);
    tick(); s_ready = 1'b1; s_last = 1'b1; settle();
    chk("nowd_done_last", m_last, 2'b01);
    tick(); m_valid = '0; s_ready = 1'b0; s_last = 1'b0;
`endif

    // ---------- report ----------
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/sim_bus_arbiter.md
# sim_bus_arbiter

Round-robin arbiter that merges `N_PORTS` cbus-style masters onto one downstream cbus slave for the Verilator simulation top, replacing separate per-bus RAM helpers with a single shared memory model. One master owns the slave port from grant until the final response beat of its transaction, including multi-beat bursts. Optional watchdog flags transactions the slave never completes.

## Interface
Parameters:
- `N_PORTS`, 2: number of masters, 1..8.
- `ADDR_W`, 32: address width.
- `DATA_W`, 64: data width; strobe width is `DATA_W/8`.
- `LEN_W`, 4: burst length field width; beats = len+1.
- `TIMEOUT`, 1024: watchdog limit in cycles; only used with the watchdog compiled in.

Ports (all per-master buses are flat, port i in slice i):
- `clk` in 1: single clock; all state is registered on its rising edge.
- `reset` in 1: synchronous, active-high.
- `m_valid` in N_PORTS: request valid.
- `m_is_write` in N_PORTS: 1 = write.
- `m_addr` in N_PORTS*ADDR_W: start address.
- `m_size` in N_PORTS*3: log2 bytes per beat.
- `m_len` in N_PORTS*LEN_W: beats-1.
- `m_strobe` in N_PORTS*DATA_W/8: write byte enables for the current beat.
- `m_data` in N_PORTS*DATA_W: write data for the current beat.
- `m_ready` out N_PORTS: beat handshake to the owner.
- `m_last` out N_PORTS: final beat to the owner.
- `m_rdata` out DATA_W: read data, broadcast to all masters.
- `s_valid`, `s_is_write`, `s_addr`, `s_size`, `s_len`, `s_strobe`, `s_data` out: the owner's request fields, same widths as one master slice.
- `s_ready` in 1, `s_last` in 1, `s_rdata` in DATA_W: slave response.
- `err` out 1: sticky watchdog error.

## Operation
- FSM states IDLE and BUSY. Registers: `owner`, `rr_ptr`, plus `wd_cnt` when the watchdog is compiled in.
- IDLE:
  - Scan `m_valid` starting at index `rr_ptr` and wrapping modulo N_PORTS.
  - On the first set bit i: set `owner`=i, go to BUSY, set `rr_ptr`=(i+1) mod N_PORTS.
  - If no bit is set, stay in IDLE.
- BUSY:
  - `s_*` request fields are combinationally muxed from master `owner`. `s_valid`=`m_valid[owner]`.
  - `m_ready[owner]`=`s_ready`. `m_last[owner]`=`s_ready & s_last`. All other `m_ready`/`m_last` bits are 0.
  - On `s_ready & s_last`, go to IDLE.
- In IDLE, all `s_*` outputs are 0, all `m_ready`/`m_last` are 0, and slave responses are ignored.
- `m_rdata` is always `s_rdata`. It is meaningful only to the owner on a read beat with `m_ready` set.
- Write bursts: the owner presents the next beat's `m_data`/`m_strobe` in the cycle after each `m_ready`. The arbiter passes these through unchanged.
- A master dropping `m_valid` while it owns the port is a protocol violation. The arbiter keeps the grant and waits for `s_last` regardless.
- With `N_PORTS`=1, `rr_ptr` is constant 0.

## Timing
- Reset values: state=IDLE, `owner`=0, `rr_ptr`=0, `err`=0, `wd_cnt`=0. All outputs are 0 in the cycle after reset.
- Reset asserted mid-transaction aborts it: the arbiter is in IDLE next cycle with no response forwarded.
- Grant latency: `m_valid` rising in cycle t puts the request on `s_valid` in cycle t+1.
- Completion in cycle t (`s_ready & s_last`) returns to IDLE at t+1. The next grant appears on `s_*` at t+2, so there is one bubble cycle between transactions.
- Response path is combinational: `s_ready`/`s_last`/`s_rdata` reach the owner in the same cycle.
- Simultaneous requests are resolved by `rr_ptr` only. A request that arrives during BUSY waits and is never reordered within a scan.

## Configuration
- Macro `SIM_BUS_WATCHDOG_EN`.
- Defined:
  - `wd_cnt` clears when entering BUSY and increments each BUSY cycle.
  - When it reaches `TIMEOUT` without completion: `err` sets (sticky until reset), the FSM forces IDLE, and the owner receives one cycle of `m_ready`=`m_last`=1 with `m_rdata`=0 so it does not hang.
- Undefined: `err` is tied to 0, no counter is present, and BUSY waits indefinitely.

## Test plan
- Single read, N_PORTS=2: port0 requests addr 0x1000, len 0; slave answers ready+last with 0xDEADBEEF_00000001 on cycle 3 -> `s_valid` from cycle 1, `m_ready[0]`=`m_last[0]`=1 with that data on cycle 3, port1 outputs stay 0.
- Contention: both ports assert valid in cycle 0 after reset -> port0 granted first, port1 granted at completion+2; with both still requesting, the next grant is port0 (alternation).
- Write burst, len=3: port1 writes 4 beats of 0x11..0x44 with the slave ready every cycle -> `s_data` shows each value in order, `m_last[1]` only on the 4th beat.
- Reset during BUSY: assert `reset` mid-burst at beat 2 -> IDLE next cycle, `s_valid`=0, `rr_ptr`=0, and the following grant goes to port0.
- N_PORTS=4 rotation: all ports requesting continuously -> grant order 0,1,2,3,0.
- Watchdog (macro defined, TIMEOUT=16): slave never asserts ready -> `err`=1 at BUSY cycle 16, owner gets one ready+last pulse, FSM returns to IDLE, and `err` stays 1 until reset.
